// File: rtl/isa_decode_pkg.sv
// isa_decode_pkg: register offsets, transmit entry layout and clog2 helper
package isa_decode_pkg;

    localparam logic [31:0] REG_TRIG     = 32'h0000_0000;
    localparam logic [31:0] REG_STEP     = 32'h0000_0004;
    localparam logic [31:0] REG_WAIT_CLR = 32'h0000_0FFC;
    localparam logic [31:0] REG_WAIT_ADD = 32'h0000_1000;

    typedef struct packed {
        logic [3:0]  ch;
        logic [31:0] addr;
        logic [31:0] payload;
    } tx_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/isa_decode_mc_if.sv
// isa_decode_mc_if: valid/ready ISA word bus from the capture stage
interface isa_decode_mc_if;

    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;

    modport master (output valid, addr, data, mask, input ready);
    modport slave  (input valid, addr, data, mask, output ready);

endinterface

// File: rtl/isa_decode_mc_tx_fifo.sv
// isa_tx_fifo: first-word fall-through FIFO with occupancy count
module isa_tx_fifo import isa_decode_pkg::*; #(
    parameter int W     = 68,
    parameter int DEPTH = 8
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic                    I_push,
    input  logic [W-1:0]            I_din,
    input  logic                    I_pop,
    output logic [W-1:0]            O_dout,
    output logic                    O_valid,
    output logic [clog2(DEPTH):0]   O_count
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;

    // Storage is written at the tail; it needs no reset because O_valid gates the head.
    always_ff @(posedge I_clk)
        if (I_push) mem_q[wr_q[AW-1:0]] <= I_din;

    // Pointers carry an extra wrap bit so full and empty differ.
    always_ff @(posedge I_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + {{AW{1'b0}}, I_push};
            rd_q <= rd_q + {{AW{1'b0}}, I_pop};
        end

    assign O_count = wr_q - rd_q;
    assign O_valid = O_count != '0;
    assign O_dout  = O_valid ? mem_q[rd_q[AW-1:0]] : '0;

endmodule

// File: rtl/isa_decode_mc.sv
// isa_decode_mc: multi-channel ISA word decoder with per-channel trigger/wait state and TX FIFO
module isa_decode_mc import isa_decode_pkg::*; #(
    parameter int          NUM_CH     = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0200_1000,
    parameter logic [31:0] CH_STRIDE  = 32'h0000_2000,
    parameter int          FIFO_DEPTH = 8,
    localparam int         CH_W       = NUM_CH > 1 ? clog2(NUM_CH) : 1
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    isa_decode_mc_if.slave        isa,
    output logic [63:0]           O_tx_data,
    output logic [CH_W-1:0]       O_tx_ch,
    output logic                  O_tx_valid,
    input  logic                  I_tx_ready,
    output logic [NUM_CH-1:0]     O_trig,
    output logic [NUM_CH*32-1:0]  O_trig_num,
    output logic [NUM_CH*32-1:0]  O_trig_step,
    output logic [NUM_CH*32-1:0]  O_wait_acc,
    output logic [NUM_CH-1:0]     O_wait_ovf,
    output logic [15:0]           O_drop_cnt
);

    localparam int          AW      = clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam int          SH      = clog2(int'(CH_STRIDE));
    localparam logic [63:0] WIN     = 64'(NUM_CH) * {32'b0, CH_STRIDE};
    localparam logic [AW:0] RDY_MAX = CW'(FIFO_DEPTH - 2);

    logic [31:0]          off, reg_off, acc_d;
    logic [CH_W-1:0]      ch;
    logic                 hit, is_trig, is_step, is_clr, is_add, push, pop, drop, ready_d;
    logic [32:0]          sum;
    logic [AW:0]          cnt, cnt_d;
    logic [NUM_CH-1:0]    trig_d;
    tx_entry_t            din, head;
    logic                 ready_q;
    logic [NUM_CH-1:0]    trig_q, ovf_q;
    logic [NUM_CH*32-1:0] num_q, step_q, acc_q;
    logic [15:0]          drop_q;

    // Decode the accepted word into a channel command and the next FIFO/ready state.
    always_comb begin
        off     = isa.addr - BASE_ADDR;
        reg_off = off & (CH_STRIDE - 32'd1);
        ch      = off[SH +: CH_W];
        hit     = isa.valid & ready_q & ({32'b0, off} < WIN);
        is_trig = hit & (isa.mask == 4'hF) & (reg_off == REG_TRIG);
        is_step = hit & (isa.mask == 4'hF) & (reg_off == REG_STEP);
        is_clr  = hit & (isa.mask == 4'hF) & (reg_off == REG_WAIT_CLR);
        is_add  = hit & (isa.mask == 4'hF) & (reg_off == REG_WAIT_ADD);
        drop    = hit & ~(is_trig | is_step | is_clr | is_add);
        sum     = {1'b0, acc_q[ch*32 +: 32]} + {1'b0, isa.data};
        acc_d   = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        push    = is_trig | is_clr | is_add;
        pop     = O_tx_valid & I_tx_ready;
        din     = '{ch: 4'(ch), addr: isa.addr, payload: is_trig ? isa.data : is_clr ? 32'h0 : acc_d};
        cnt_d   = cnt + CW'(push) - CW'(pop);
        ready_d = cnt_d <= RDY_MAX;
        trig_d  = is_trig ? NUM_CH'(1) << ch : '0;
    end

    // Per-channel state, trigger pulse, drop counter and registered ready.
    always_ff @(posedge I_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            ready_q <= 1'b0;
            trig_q  <= '0;
            ovf_q   <= '0;
            num_q   <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            drop_q  <= '0;
        end else begin
            ready_q <= ready_d;
            trig_q  <= trig_d;
            if (is_trig) num_q[ch*32 +: 32] <= isa.data;
            if (is_step) step_q[ch*32 +: 32] <= isa.data;
            if (is_clr) begin
                acc_q[ch*32 +: 32] <= '0;
                ovf_q[ch]          <= 1'b0;
            end
            if (is_add) begin
                acc_q[ch*32 +: 32] <= acc_d;
                if (sum[32]) ovf_q[ch] <= 1'b1;
            end
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end

    isa_tx_fifo #(.W($bits(tx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_push  (push),
        .I_din   (din),
        .I_pop   (pop),
        .O_dout  (head),
        .O_valid (O_tx_valid),
        .O_count (cnt)
    );

    assign isa.ready   = ready_q;
    assign O_tx_data   = {head.addr, head.payload};
    assign O_tx_ch     = CH_W'(head.ch);
    assign O_trig      = trig_q;
    assign O_trig_num  = num_q;
    assign O_trig_step = step_q;
    assign O_wait_acc  = acc_q;
    assign O_wait_ovf  = ovf_q;
    assign O_drop_cnt  = drop_q;

endmodule

// File: tb/tb_isa_decode_mc.sv
// tb_isa_decode_mc: randomized scoreboard bench for isa_decode_mc against a behavioural model
module tb_isa_decode_mc;

    localparam int          NCH   = 4;
    localparam logic [31:0] BASE  = 32'h0200_1000;
    localparam logic [31:0] STR   = 32'h0000_2000;
    localparam int          DEPTH = 8;

    typedef struct {
        logic [63:0] data;
        int          ch;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                tx_ready = 1'b0;
    logic [63:0]         tx_data;
    logic [1:0]          tx_ch;
    logic                tx_valid;
    logic [NCH-1:0]      trig, wait_ovf;
    logic [NCH*32-1:0]   trig_num, trig_step, wait_acc;
    logic [15:0]         drop_cnt;

    int                  checks = 0;
    int                  errors = 0;
    int                  tx_mode = 1;
    logic [31:0]         m_num [NCH];
    logic [31:0]         m_step[NCH];
    logic [31:0]         m_acc [NCH];
    logic                m_ovf [NCH];
    int                  m_drop = 0;
    logic [NCH-1:0]      exp_trig = '0;
    exp_t                q[$];

    isa_decode_mc_if isa();

    isa_decode_mc #(.NUM_CH(NCH), .BASE_ADDR(BASE), .CH_STRIDE(STR), .FIFO_DEPTH(DEPTH)) dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .isa         (isa),
        .O_tx_data   (tx_data),
        .O_tx_ch     (tx_ch),
        .O_tx_valid  (tx_valid),
        .I_tx_ready  (tx_ready),
        .O_trig      (trig),
        .O_trig_num  (trig_num),
        .O_trig_step (trig_step),
        .O_wait_acc  (wait_acc),
        .O_wait_ovf  (wait_ovf),
        .O_drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_num[c] = 0; m_step[c] = 0; m_acc[c] = 0; m_ovf[c] = 0;
        end
        m_drop = 0;
        exp_trig = '0;
        q.delete();
    endfunction

    // Reference behaviour: plain address arithmetic and 64-bit sums.
    function automatic void model_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int unsigned off, c, r;
        longint unsigned s;
        off = a - BASE;
        if (off >= NCH * STR) return;
        c = off / STR;
        r = off % STR;
        if (m != 4'hF || !(r == 0 || r == 4 || r == 'hFFC || r == 'h1000)) begin
            if (m_drop < 65535) m_drop++;
            return;
        end
        if (r == 0) begin
            m_num[c] = d;
            exp_trig[c] = 1'b1;
            q.push_back('{data: {a, d}, ch: c});
        end else if (r == 4) begin
            m_step[c] = d;
        end else if (r == 'hFFC) begin
            m_acc[c] = 0;
            m_ovf[c] = 0;
            q.push_back('{data: {a, 32'h0}, ch: c});
        end else begin
            s = 64'(m_acc[c]) + 64'(d);
            if (s > 64'hFFFF_FFFF) begin
                m_acc[c] = 32'hFFFF_FFFF;
                m_ovf[c] = 1'b1;
            end else m_acc[c] = s[31:0];
            q.push_back('{data: {a, m_acc[c]}, ch: c});
        end
    endfunction

    task automatic step_ready();
        tx_ready = (tx_mode == 2) ? ($urandom_range(3) != 0) : (tx_mode == 1);
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output bit took);
        step_ready();
        isa.valid = 1'b1; isa.addr = a; isa.data = d; isa.mask = m;
        @(negedge clk);
        took = isa.ready;
        @(posedge clk);
        if (took) model_apply(a, d, m);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bit took;
        took = 0;
        for (int t = 0; t < 100 && !took; t++) cyc(a, d, m, took);
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr %h not accepted within 100 cycles", a);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step_ready();
            isa.valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Register-state checker: every cycle compares DUT state with the model.
    always @(negedge clk) begin
        check("trig", 64'(trig), 64'(exp_trig));
        exp_trig = '0;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("trig_num[%0d]", c), 64'(trig_num[c*32 +: 32]), 64'(m_num[c]));
            check($sformatf("trig_step[%0d]", c), 64'(trig_step[c*32 +: 32]), 64'(m_step[c]));
            check($sformatf("wait_acc[%0d]", c), 64'(wait_acc[c*32 +: 32]), 64'(m_acc[c]));
            check($sformatf("wait_ovf[%0d]", c), 64'(wait_ovf[c]), 64'(m_ovf[c]));
        end
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end

    // TX monitor: pops the expected queue whenever the head is consumed.
    always @(negedge clk) begin
        exp_t e;
        if (tx_valid && tx_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %h with empty expectation queue", tx_data);
            end else begin
                e = q.pop_front();
                check("tx_data", tx_data, e.data);
                check("tx_ch", 64'(tx_ch), 64'(e.ch));
            end
        end
    end

    initial begin
        int n;
        bit took;
        logic [15:0] d0;
        logic [31:0] a, d;
        logic [3:0] m;
        int sel, c;
        rst_n = 1'b0;
        isa.valid = 1'b0; isa.addr = '0; isa.data = '0; isa.mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", 64'(isa.ready), 64'd0);
        check("txv_in_reset", 64'(tx_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 64'(isa.ready), 64'd1);

        send(32'h0200_3000, 32'h5, 4'hF);
        idle(3);

        send(32'h0200_1FFC, 32'hABCD, 4'hF);
        send(32'h0200_2000, 32'h10, 4'hF);
        send(32'h0200_2000, 32'h20, 4'hF);
        idle(3);
        check("acc0_chain", 64'(wait_acc[31:0]), 64'h30);

        send(32'h0200_6000, 32'hFFFF_FFF0, 4'hF);
        send(32'h0200_6000, 32'h20, 4'hF);
        idle(2);
        check("acc2_sat", 64'(wait_acc[95:64]), 64'hFFFF_FFFF);
        check("ovf2_set", 64'(wait_ovf[2]), 64'd1);
        send(32'h0200_5FFC, 32'h0, 4'hF);
        idle(2);
        check("acc2_clr", 64'(wait_acc[95:64]), 64'd0);
        check("ovf2_clr", 64'(wait_ovf[2]), 64'd0);

        d0 = drop_cnt;
        send(32'h0200_1000, 32'h9, 4'h7);
        send(32'h0200_1008, 32'h1, 4'hF);
        send(32'h0300_0000, 32'h1, 4'hF);
        idle(3);
        check("drop_delta", 64'(drop_cnt), 64'(d0 + 16'd2));
        check("drop_no_push", 64'(tx_valid), 64'd0);

        tx_mode = 0;
        idle(1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(BASE + (i % NCH) * STR, 32'd100 + i, 4'hF, took);
            n += took;
        end
        check("stream_accepts", 64'(n), 64'd7);
        check("stream_ready_low", 64'(isa.ready), 64'd0);
        check("stream_queued", 64'(q.size()), 64'd7);
        tx_mode = 1;
        idle(12);
        check("stream_drained", 64'(q.size()), 64'd0);

        tx_mode = 0;
        send(32'h0200_1000, 32'h11, 4'hF);
        send(32'h0200_2000, 32'h22, 4'hF);
        send(32'h0200_3000, 32'h33, 4'hF);
        idle(2);
        check("pre_reset_txv", 64'(tx_valid), 64'd1);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_txv", 64'(tx_valid), 64'd0);
        check("rst_ready", 64'(isa.ready), 64'd0);
        check("rst_acc", 64'(wait_acc), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 64'(isa.ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 64'(isa.ready), 64'd1);
        check("txv_after_reset", 64'(tx_valid), 64'd0);

        tx_mode = 2;
        for (int i = 0; i < 500; i++) begin
            c = $urandom_range(NCH - 1);
            sel = $urandom_range(9);
            d = $urandom;
            m = 4'hF;
            a = BASE + c * STR;
            if (sel == 2) a += 32'h4;
            else if (sel == 3) a += 32'hFFC;
            else if (sel >= 4 && sel <= 6) begin
                a += 32'h1000;
                if ($urandom_range(1) == 1) d = $urandom_range(255);
            end else if (sel == 7) a += 32'h8;
            else if (sel == 8) a = $urandom;
            else if (sel == 9) m = 4'($urandom_range(15));
            send(a, d, m);
            if ($urandom_range(3) == 0) idle(1);
        end
        tx_mode = 1;
        idle(20);
        check("final_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
